// File: rtl/adder_pkg.sv
// Shared types for the adder result buffer: result word layout and
// occupancy state encoding.
package adder_pkg;

    localparam int ADDER_W = 4;
    localparam int RES_W   = ADDER_W + 1;

    typedef struct packed {
        logic               ovf;
        logic [ADDER_W-1:0] sum;
    } result_t;

    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'b00,
        BUF_PARTIAL = 2'b01,
        BUF_FULL    = 2'b10
    } buf_state_t;

endpackage

// File: rtl/result_buf_mem.sv
// Result storage: DEPTH x RES_W register array, one synchronous write port
// and one asynchronous read port. No reset; contents are qualified by the
// occupancy logic in adder_result_buf.
module result_buf_mem
    import adder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  result_t                  wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output result_t                  rd_data
);

    result_t mem [DEPTH];

    // Write port: one entry per edge when enabled.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/adder_result_buf.sv
// Circular buffer capturing registered adder results ({Overflow,Sum}) one
// cycle after the adder's enable, with valid/ready drain, sticky drop flag
// and an optional overflow-result counter.
// Build option: define ADDER_RESULT_BUF_OVF_CNT_EN to build the Ovf_Count
// counter; otherwise Ovf_Count is tied to zero.
//
// state       | meaning
// BUF_EMPTY   | no entries stored, Out_Valid low
// BUF_PARTIAL | 1..DEPTH-1 entries stored
// BUF_FULL    | DEPTH entries stored, a push needs a same-edge pop
module adder_result_buf
    import adder_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int OVF_CNT_W = 8
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   En,
    input  logic [ADDER_W-1:0]     Sum,
    input  logic                   Overflow,
    output logic [RES_W-1:0]       Out_Data,
    output logic                   Out_Valid,
    input  logic                   Out_Ready,
    output logic [$clog2(DEPTH):0] Count,
    output logic                   Full,
    output logic                   Empty,
    output logic                   Drop,
    output logic [OVF_CNT_W-1:0]   Ovf_Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic          en_d;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;
    buf_state_t    state_q;
    buf_state_t    state_nxt;
    logic          drop_q;
    logic          push;
    logic          pop;
    logic          wr_accept;
    logic          state_bad;
    result_t       wr_data;
    result_t       rd_data;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign wr_data = {Overflow, Sum};

    // Decode flags from state and work out this edge's push/pop and next occupancy.
    always_comb begin
        Out_Valid = (state_q == BUF_PARTIAL) || (state_q == BUF_FULL);
        Full      = (state_q == BUF_FULL);
        Empty     = !Out_Valid;
        state_bad = !((state_q == BUF_EMPTY) || Out_Valid);
        push      = en_d;
        pop       = Out_Valid && Out_Ready;
        // When full, a push only lands if the head leaves on the same edge.
        wr_accept = push && (!Full || pop);
        count_nxt = count_q + CW'(wr_accept) - CW'(pop);
        if (state_bad || (count_nxt == '0)) begin
            state_nxt = BUF_EMPTY;
        end else if (count_nxt == CW'(DEPTH)) begin
            state_nxt = BUF_FULL;
        end else begin
            state_nxt = BUF_PARTIAL;
        end
        Out_Data = Out_Valid ? rd_data : '0;
    end

    // Pointers, occupancy, state and sticky drop flag.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            en_d    <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            state_q <= BUF_EMPTY;
            drop_q  <= 1'b0;
        end else begin
            en_d    <= En;
            state_q <= state_nxt;
            if (state_bad) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (wr_accept) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                count_q <= count_nxt;
            end
            if (push && !wr_accept) begin
                drop_q <= 1'b1;
            end
        end
    end

    assign Count = count_q;
    assign Drop  = drop_q;

    result_buf_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .Clk     (Clk),
        .wr_en   (wr_accept && !state_bad),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

`ifdef ADDER_RESULT_BUF_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] ovf_cnt_q;

    // Count accepted results with Overflow set, saturating at all-ones.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            ovf_cnt_q <= '0;
        end else if (wr_accept && !state_bad && Overflow && (ovf_cnt_q != '1)) begin
            ovf_cnt_q <= ovf_cnt_q + OVF_CNT_W'(1);
        end
    end

    assign Ovf_Count = ovf_cnt_q;
`else
    assign Ovf_Count = '0;
`endif

endmodule

// File: tb/tb_adder_result_buf.sv
// Self-checking bench for adder_result_buf: a small registered adder feeds
// the DUT, and a queue-based reference model predicts every output.
module tb_adder_result_buf;
    import adder_pkg::*;

    localparam int DEPTH     = 4;
    localparam int OVF_CNT_W = 4;
    localparam int CW        = $clog2(DEPTH) + 1;
    localparam int OVF_MAX   = (1 << OVF_CNT_W) - 1;

    logic                 Clk = 1'b0;
    logic                 Rst_n;
    logic                 En;
    logic                 Out_Ready;
    logic [3:0]           A;
    logic [3:0]           B;
    logic [3:0]           sum_r = '0;
    logic                 ovf_r = 1'b0;
    logic [RES_W-1:0]     Out_Data;
    logic                 Out_Valid;
    logic [CW-1:0]        Count;
    logic                 Full;
    logic                 Empty;
    logic                 Drop;
    logic [OVF_CNT_W-1:0] Ovf_Count;

    int checks = 0;
    int errors = 0;

    adder_result_buf #(
        .DEPTH     (DEPTH),
        .OVF_CNT_W (OVF_CNT_W)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .En        (En),
        .Sum       (sum_r),
        .Overflow  (ovf_r),
        .Out_Data  (Out_Data),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Count     (Count),
        .Full      (Full),
        .Empty     (Empty),
        .Drop      (Drop),
        .Ovf_Count (Ovf_Count)
    );

    always #5 Clk = ~Clk;

    // Registered 4-bit adder: carry out is the Overflow flag.
    always @(posedge Clk) begin
        if (En) {ovf_r, sum_r} <= {1'b0, A} + {1'b0, B};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a queue of results, a one-cycle enable delay,
    // a sticky drop bit and a saturating overflow count.
    int q[$];
    bit m_en_d = 0;
    bit m_drop = 0;
    int m_ovf  = 0;
    bit m_pop;
    int m_sz;

    always @(posedge Clk) begin
        if (!Rst_n) begin
            q.delete();
            m_en_d = 0;
            m_drop = 0;
            m_ovf  = 0;
        end else begin
            m_sz  = q.size();
            m_pop = (m_sz > 0) && Out_Ready;
            if (m_pop) void'(q.pop_front());
            if (m_en_d) begin
                if (m_sz < DEPTH || m_pop) begin
                    q.push_back(int'({ovf_r, sum_r}));
                    if (ovf_r && m_ovf < OVF_MAX) m_ovf++;
                end else begin
                    m_drop = 1;
                end
            end
            m_en_d = En;
        end
    end

    function automatic int exp_ovf(input int n);
`ifdef ADDER_RESULT_BUF_OVF_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    bit chk_on = 0;

    // Compare every output against the model away from the active edge.
    always @(negedge Clk) begin
        if (chk_on) begin
            chk("m_valid", Out_Valid, q.size() > 0);
            chk("m_data",  Out_Data, (q.size() > 0) ? q[0] : 0);
            chk("m_count", Count, q.size());
            chk("m_full",  Full, q.size() == DEPTH);
            chk("m_empty", Empty, q.size() == 0);
            chk("m_drop",  Drop, m_drop);
            chk("m_ovf",   Ovf_Count, exp_ovf(m_ovf));
        end
    end

    task automatic do_reset();
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    initial begin
        Rst_n = 1'b0; En = 1'b0; A = '0; B = '0; Out_Ready = 1'b0;
        repeat (2) @(negedge Clk);
        chk_on = 1;
        Rst_n = 1'b1;
        @(negedge Clk);
        chk("rst_empty", Empty, 1);
        chk("rst_full",  Full, 0);
        chk("rst_valid", Out_Valid, 0);
        chk("rst_data",  Out_Data, 0);
        chk("rst_drop",  Drop, 0);
        chk("rst_ovf",   Ovf_Count, 0);

        // 3 + 4: visible two edges after the En edge
        A = 4'd3; B = 4'd4; En = 1'b1;
        @(negedge Clk);
        En = 1'b0;
        chk("lat_early", Out_Valid, 0);
        @(negedge Clk);
        chk("lat_valid", Out_Valid, 1);
        chk("lat_data",  Out_Data, 5'b00111);
        Out_Ready = 1'b1;
        @(negedge Clk);
        chk("pop_empty", Empty, 1);
        Out_Ready = 1'b0;

        // 9 + 9: overflow result
        A = 4'd9; B = 4'd9; En = 1'b1;
        @(negedge Clk);
        En = 1'b0;
        @(negedge Clk);
        chk("ovf_data", Out_Data, 5'b10010);
        chk("ovf_cnt",  Ovf_Count, exp_ovf(1));
        Out_Ready = 1'b1;
        @(negedge Clk);
        Out_Ready = 1'b0;

        // Five results into a four-deep buffer with no drain
        for (int v = 1; v <= 5; v++) begin
            A = 4'(v); B = 4'd0; En = 1'b1;
            @(negedge Clk);
        end
        En = 1'b0;
        @(negedge Clk);
        chk("ovr_full",  Full, 1);
        chk("ovr_count", Count, 4);
        chk("ovr_drop",  Drop, 1);
        Out_Ready = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            chk("drain", Out_Data, v);
            @(negedge Clk);
        end
        chk("drain_empty", Empty, 1);
        Out_Ready = 1'b0;

        // Full with continuous push and pop across pointer wrap
        do_reset();
        En = 1'b1;
        for (int i = 0; i < 20 && !Full; i++) begin
            A = 4'($urandom); B = 4'($urandom);
            @(negedge Clk);
        end
        chk("fill_full", Full, 1);
        Out_Ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            A = 4'($urandom); B = 4'($urandom);
            @(negedge Clk);
            chk("steady_count", Count, 4);
            chk("steady_drop",  Drop, 0);
        end
        En = 1'b0;
        repeat (6) @(negedge Clk);
        chk("steady_drained", Empty, 1);
        Out_Ready = 1'b0;

        // Reset with three entries stored and a write pending
        A = 4'd15; B = 4'd15; En = 1'b1;
        for (int i = 0; i < 20 && Count != 3; i++) @(negedge Clk);
        chk("pre_rst_count", Count, 3);
        Rst_n = 1'b0;
        @(negedge Clk);
        chk("mid_rst_empty", Empty, 1);
        chk("mid_rst_valid", Out_Valid, 0);
        chk("mid_rst_data",  Out_Data, 0);
        chk("mid_rst_drop",  Drop, 0);
        chk("mid_rst_ovf",   Ovf_Count, 0);
        Rst_n = 1'b1; En = 1'b0;
        repeat (4) begin
            @(negedge Clk);
            chk("post_rst_empty", Empty, 1);
        end

        // Overflow counter saturation
        Out_Ready = 1'b1; A = 4'd15; B = 4'd15; En = 1'b1;
        repeat (200) @(negedge Clk);
        En = 1'b0;
        repeat (3) @(negedge Clk);
        chk("ovf_sat", Ovf_Count, exp_ovf(15));

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            Rst_n     = ($urandom_range(0, 63) != 0);
            En        = ($urandom_range(0, 3) != 0);
            Out_Ready = ($urandom_range(0, 2) == 0);
            A         = 4'($urandom);
            B         = 4'($urandom);
            @(negedge Clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_result_buf.md
ADDER_RESULT_BUF -- requirements
Module: adder_result_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of result entries; it SHALL be a power of two, 2..16.
REQ-002 SHALL have parameter OVF_CNT_W, default 8, meaning the overflow counter width.
REQ-003 Clk  input  1  the single clock; all state updates on posedge Clk.
REQ-004 Rst_n  input  1  reset, synchronous and active-low.
REQ-005 En  input  1  the adder's enable, the same net that drives the adder.
REQ-006 Sum  input  4  the adder's registered Sum.
REQ-007 Overflow  input  1  the adder's registered Overflow.
REQ-008 Out_Data  output  5  head entry {Overflow,Sum}.
REQ-009 Out_Valid  output  1  head entry present.
REQ-010 Out_Ready  input  1  consumer accepts the head.
REQ-011 Count  output  $clog2(DEPTH)+1  occupancy.
REQ-012 Full / Empty  output  1 each  Count==DEPTH / Count==0.
REQ-013 Drop  output  1  sticky: a result was lost because the buffer was full.
REQ-014 Ovf_Count  output  OVF_CNT_W  number of captured results with Overflow=1.

Function
REQ-015 SHALL register En into en_d on every Clk edge; a write occurs on an edge where en_d==1, capturing {Overflow,Sum}.
REQ-016 Latency: En high before edge t -> adder result updates at t -> write at t+1 -> Out_Valid high after t+1, Out_Data valid in the same cycle.
REQ-017 A pop occurs on an edge where Out_Valid && Out_Ready; Out_Data SHALL advance to the next entry after that edge.
REQ-018 Out_Data SHALL be stable while Out_Valid && !Out_Ready.
REQ-019 Out_Data SHALL be 5'd0 when Empty.
REQ-020 Storage SHALL be a circular buffer with wr_ptr/rd_ptr wrapping from DEPTH-1 to 0.
REQ-021 Push && pop, not Full: both occur and Count is unchanged.
REQ-022 Push && pop && Full: both occur, the write lands in the freed slot, Count stays DEPTH, and Drop is unchanged.
REQ-023 Push && !pop && Full: the write is discarded, pointers hold, and Drop is set to 1.
REQ-024 Push && Empty: Out_Valid rises the next cycle; there is no same-cycle bypass.
REQ-025 Drop SHALL clear only on reset.
REQ-026 Ovf_Count SHALL increment on each accepted write with Overflow==1 and saturate at all-ones; a discarded write SHALL NOT count.
REQ-027 Occupancy FSM states: EMPTY, PARTIAL, FULL.
  - Transitions follow the net push/pop.
  - Full and Empty are decoded from the state.
  - Count is kept as a register.
  - An illegal state SHALL return to EMPTY.

Reset
REQ-028 When Rst_n==0 at an edge, the block SHALL take its reset values:
  - en_d=0, wr_ptr=rd_ptr=0, Count=0, state=EMPTY.
  - Empty=1, Full=0, Out_Valid=0, Out_Data=0, Drop=0, Ovf_Count=0.
REQ-029 Reset mid-operation SHALL discard all buffered entries and any en_d pending write; storage contents need not be cleared.
REQ-030 An En pulse in the cycle where Rst_n==0 SHALL NOT produce a write after reset releases.

Configuration
REQ-031 Macro ADDER_RESULT_BUF_OVF_CNT_EN:
  - Defined: the Ovf_Count register and its logic are present per REQ-026.
  - Undefined: no counter is built, Ovf_Count is tied to 0, and the port is kept.

Structure
REQ-032 Package adder_pkg SHALL hold:
  - ADDER_W=4 and RES_W=ADDER_W+1.
  - typedef result_t, a packed {ovf, sum[ADDER_W-1:0]}.
  - The occupancy state enum buf_state_t.
REQ-033 Sub-module result_buf_mem SHALL hold the DEPTH x RES_W register array with one write port and one asynchronous read port.
  - Control, pointers and FSM stay in adder_result_buf.

Verification
REQ-034 Reset, then En=1 for one cycle with A=3, B=4 (Sum=7, Overflow=0).
  - Out_Valid is high 2 edges after the En edge and Out_Data=5'b00111.
  - Out_Ready=1 -> Empty=1 the next cycle.
REQ-035 A=9, B=9 with En=1 gives Out_Data=5'b10010 and Ovf_Count=1.
  - Repeat with the macro undefined -> Ovf_Count=0.
REQ-036 Out_Ready=0 and 5 consecutive En results, values 1..5 (DEPTH=4).
  - Full=1, Count=4, Drop=1.
  - Then drain: reads return 1,2,3,4.
REQ-037 Full with En continuous and Out_Ready=1 continuous.
  - Count stays 4 and Drop stays 0.
  - Outputs appear in write order across pointer wrap.
REQ-038 Rst_n=0 for one edge with Count=3 and en_d=1.
  - Next cycle: Empty=1, Out_Valid=0, Out_Data=0, Drop=0, Ovf_Count=0.
  - No write occurs afterwards.
REQ-039 200 Ovf results with OVF_CNT_W=4 and Out_Ready=1 -> Ovf_Count saturates at 15.
